// File: rtl/m68k_bus_master.sv
// rtl/m68k_bus_master.sv - 68000-style bus initiator: client word/byte requests to AS/DS/DTACK cycles
module m68k_bus_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic        i_size,
  input  logic [23:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_busy,
  output logic        o_ack,
  output logic        o_err,
  output logic [15:0] o_rdata,
  output logic [22:0] o_A,
  output logic        o_AS_n,
  output logic        o_UDS_n,
  output logic        o_LDS_n,
  output logic        o_RW,
  output logic [15:0] o_D,
  output logic        o_D_oe,
  input  logic [15:0] i_D,
  input  logic        i_DTACK_n,
  input  logic        i_BERR_n
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4, S_REC} state_t;

  state_t        state_q, state_d;
  logic          rw_q, rw_d;
  logic          size_q, size_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_flag_q, err_flag_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [22:0]   a_q, a_d;
  logic          as_n_q, as_n_d;
  logic          uds_n_q, uds_n_d;
  logic          lds_n_q, lds_n_d;
  logic          rw_out_q, rw_out_d;
  logic [15:0]   d_q, d_d;
  logic          d_oe_q, d_oe_d;

  logic uds_en, lds_en;

  assign uds_en = size_q | ~addr_q[0];
  assign lds_en = size_q | addr_q[0];

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    a_d        = a_q;
    as_n_d     = as_n_q;
    uds_n_d    = uds_n_q;
    lds_n_d    = lds_n_q;
    rw_out_d   = rw_out_q;
    d_d        = d_q;
    d_oe_d     = d_oe_q;
    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        a_d      = '0;
        d_d      = '0;
        as_n_d   = 1'b1;
        uds_n_d  = 1'b1;
        lds_n_d  = 1'b1;
        rw_out_d = 1'b1;
        d_oe_d   = 1'b0;
        if (i_req) begin
          rw_d       = i_rw;
          size_d     = i_size;
          addr_d     = i_addr;
          wdata_d    = i_wdata;
          busy_d     = 1'b1;
          // Odd word address never reaches the bus
          err_flag_d = i_size & i_addr[0];
          state_d    = (i_size & i_addr[0]) ? S_REC : S_T1;
        end
      end
      S_T1: begin
        a_d      = addr_q[23:1];
        rw_out_d = rw_q;
        if (!rw_q) d_d = wdata_q;
        state_d  = S_T2;
      end
      S_T2: begin
        as_n_d = 1'b0;
        if (rw_q) begin
          uds_n_d = ~uds_en;
          lds_n_d = ~lds_en;
        end else begin
          d_oe_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_T3;
      end
      S_T3: begin
        as_n_d  = 1'b0;
        uds_n_d = ~uds_en;
        lds_n_d = ~lds_en;
        d_oe_d  = ~rw_q;
        if (!i_BERR_n) begin
          err_flag_d = 1'b1;
          state_d    = S_T4;
        end else if (!i_DTACK_n) begin
          if (rw_q) rdata_d = i_D;
          state_d = S_T4;
        end else if (cnt_q == CNT_MAX) begin
          err_flag_d = 1'b1;
          state_d    = S_T4;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_T4: begin
        as_n_d  = 1'b1;
        uds_n_d = 1'b1;
        lds_n_d = 1'b1;
        state_d = S_REC;
      end
      S_REC: begin
        ack_d    = 1'b1;
        err_d    = err_flag_q;
        d_oe_d   = 1'b0;
        rw_out_d = 1'b1;
        if (err_flag_q && rw_q) rdata_d = 16'hFFFF;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b1;
      size_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_flag_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      a_q        <= '0;
      as_n_q     <= 1'b1;
      uds_n_q    <= 1'b1;
      lds_n_q    <= 1'b1;
      rw_out_q   <= 1'b1;
      d_q        <= '0;
      d_oe_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      a_q        <= a_d;
      as_n_q     <= as_n_d;
      uds_n_q    <= uds_n_d;
      lds_n_q    <= lds_n_d;
      rw_out_q   <= rw_out_d;
      d_q        <= d_d;
      d_oe_q     <= d_oe_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_ack   = ack_q;
  assign o_err   = err_q;
  assign o_rdata = rdata_q;
  assign o_A     = a_q;
  assign o_AS_n  = as_n_q;
  assign o_UDS_n = uds_n_q;
  assign o_LDS_n = lds_n_q;
  assign o_RW    = rw_out_q;
  assign o_D     = d_q;
  assign o_D_oe  = d_oe_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// tb/tb_m68k_bus_master.sv - vector table plus scoreboard bench for m68k_bus_master
module tb_m68k_bus_master;

  localparam int TO = 8;
  localparam int NEVER = 99;

  logic        i_CLK = 1'b0;
  logic        i_RST, i_req, i_rw, i_size;
  logic [23:0] i_addr;
  logic [15:0] i_wdata, i_D;
  logic        i_DTACK_n, i_BERR_n;
  logic        o_busy, o_ack, o_err, o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D_oe;
  logic [15:0] o_rdata, o_D;
  logic [22:0] o_A;

  always #5 i_CLK = ~i_CLK;

  m68k_bus_master #(.TIMEOUT(TO)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_req(i_req), .i_rw(i_rw), .i_size(i_size),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_ack(o_ack), .o_err(o_err),
    .o_rdata(o_rdata), .o_A(o_A), .o_AS_n(o_AS_n), .o_UDS_n(o_UDS_n), .o_LDS_n(o_LDS_n),
    .o_RW(o_RW), .o_D(o_D), .o_D_oe(o_D_oe), .i_D(i_D), .i_DTACK_n(i_DTACK_n),
    .i_BERR_n(i_BERR_n)
  );

  typedef struct {
    logic        rw;
    logic        size;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    int          dtack_edge;
    int          berr_edge;
    int          ack_cyc;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_rdata;
    logic [15:0] rdata;
    int          abs_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_abs = 0;

  always @(posedge i_CLK) cyc_abs <= cyc_abs + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge i_CLK) begin : mon
    exp_t e;
    if (o_ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", cyc_abs, e.abs_cyc);
        check("ack_err", o_err, e.err);
        if (e.chk_rdata) check("ack_rdata", o_rdata, e.rdata);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int   e;
    logic aerr, dsw, ue, le;
    logic [6:0] fexp;
    aerr = (v.ack_cyc == 1);
    e    = v.ack_cyc - 2;
    ue   = v.size | ~v.addr[0];
    le   = v.size | v.addr[0];
    @(negedge i_CLK);
    i_req = 1'b1; i_rw = v.rw; i_size = v.size; i_addr = v.addr; i_wdata = v.wdata;
    i_D = v.rd;
    i_DTACK_n = !(v.dtack_edge <= 0);
    i_BERR_n  = !(v.berr_edge <= 0);
    sb.push_back('{v.err, v.rw, v.rdata, cyc_abs + 1 + v.ack_cyc});
    @(posedge i_CLK);
    #1;
    i_req = 1'b0; i_addr = ~v.addr; i_wdata = ~v.wdata; i_rw = ~v.rw; i_size = ~v.size;
    for (int c = 0; c <= v.ack_cyc + 1; c++) begin
      @(negedge i_CLK);
      if (aerr) begin
        fexp = {4'b1111, 1'b0, (c <= 1), (c == 1)};
      end else begin
        dsw  = v.rw ? (c >= 2 && c <= e) : (c >= 3 && c <= e);
        fexp = {!(c >= 2 && c <= e), !(dsw && ue), !(dsw && le),
                !(!v.rw && c >= 1 && c <= e + 1), (!v.rw && c >= 2 && c <= e + 1),
                (c <= e + 2), (c == e + 2)};
      end
      check($sformatf("v%0d_c%0d_bus", idx, c),
            {o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D_oe, o_busy, o_ack}, fexp);
      if (!aerr && c >= 1 && c <= e + 1) begin
        check($sformatf("v%0d_c%0d_A", idx, c), o_A, v.addr[23:1]);
        if (!v.rw) check($sformatf("v%0d_c%0d_D", idx, c), o_D, v.wdata);
      end
      if (c == 0 || c == v.ack_cyc + 1)
        check($sformatf("v%0d_c%0d_A_idle", idx, c), o_A, 23'h0);
      i_DTACK_n = !(v.dtack_edge <= c + 1);
      i_BERR_n  = !(v.berr_edge <= c + 1);
    end
    i_DTACK_n = 1'b1;
    i_BERR_n  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 24'hE00000, 16'h0000, 16'h4E71, 0,     NEVER, 5,  1'b0, 16'h4E71};
    tbl[1]  = '{1'b0, 1'b0, 24'h000001, 16'h00A5, 16'h0000, 6,     NEVER, 8,  1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 24'h000100, 16'h0000, 16'h1111, NEVER, NEVER, 12, 1'b1, 16'hFFFF};
    tbl[3]  = '{1'b1, 1'b1, 24'h000200, 16'h0000, 16'h2222, 3,     3,     5,  1'b1, 16'hFFFF};
    tbl[4]  = '{1'b1, 1'b1, 24'h000003, 16'h0000, 16'h3333, 0,     NEVER, 1,  1'b1, 16'hFFFF};
    tbl[5]  = '{1'b1, 1'b0, 24'h000010, 16'h0000, 16'h1234, 4,     NEVER, 6,  1'b0, 16'h1234};
    tbl[6]  = '{1'b0, 1'b0, 24'h000020, 16'hAB00, 16'h0000, 3,     NEVER, 5,  1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 24'h000040, 16'hBEEF, 16'h0000, NEVER, 5,     7,  1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 24'h000041, 16'hCAFE, 16'h0000, 0,     NEVER, 1,  1'b1, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 24'h7FFFFE, 16'h0000, 16'h8001, 10,    NEVER, 12, 1'b0, 16'h8001};
    tbl[10] = '{1'b1, 1'b1, 24'h000300, 16'h0000, 16'h5A5A, 11,    NEVER, 12, 1'b1, 16'hFFFF};
    tbl[11] = '{1'b1, 1'b0, 24'hFFFFFF, 16'h0000, 16'hC3C3, 3,     4,     5,  1'b0, 16'hC3C3};

    i_RST = 1'b1; i_req = 1'b0; i_rw = 1'b1; i_size = 1'b0; i_addr = '0; i_wdata = '0;
    i_D = '0; i_DTACK_n = 1'b1; i_BERR_n = 1'b1;
    repeat (3) @(posedge i_CLK);
    #1 i_RST = 1'b0;
    @(negedge i_CLK);
    check("reset_ctl", {o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D_oe, o_busy, o_ack, o_err}, 8'b1111_0000);
    check("reset_data", {o_A, o_D, o_rdata}, 55'h0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Reset while a write sits in T3: no completion, bus released at once
    @(negedge i_CLK);
    i_req = 1'b1; i_rw = 1'b0; i_size = 1'b1; i_addr = 24'h000200; i_wdata = 16'h5555;
    i_DTACK_n = 1'b1;
    @(posedge i_CLK);
    #1 i_req = 1'b0;
    repeat (4) @(negedge i_CLK);
    check("rst_pre_T3", {o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D_oe, o_busy}, 6'b000011);
    i_RST = 1'b1;
    @(negedge i_CLK);
    check("rst_abort", {o_AS_n, o_UDS_n, o_LDS_n, o_RW, o_D_oe, o_busy, o_ack}, 7'b1111000);
    i_RST = 1'b0;
    repeat (8) @(negedge i_CLK);
    run_vec(tbl[0], 100);
    repeat (3) @(negedge i_CLK);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
